// File: rtl/daq_capture_ctrl_if.sv
// daq_capture_ctrl_if: sensor pixel bus and transmit-FIFO write port
interface daq_capture_ctrl_if;
  logic       pix_stb;
  logic       frame_vaild;
  logic       line_vaild;
  logic [7:0] pix_data;
  logic       fifo_full;
  logic       wr_en;
  logic [9:0] wr_data;
  modport master (output pix_stb, frame_vaild, line_vaild, pix_data, fifo_full, input wr_en, wr_data);
  modport slave  (input pix_stb, frame_vaild, line_vaild, pix_data, fifo_full, output wr_en, wr_data);
endinterface

// File: rtl/daq_capture_ctrl.sv
// daq_capture_ctrl: frame-aligned sensor capture into the transmit FIFO with
// decimation, sof/eol tagging and line/frame geometry checking.
module daq_capture_ctrl #(
  parameter int LINE_MAX    = 100,
  parameter int FRAME_LINES = 20,
  parameter int FCNT_W      = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              single,
  input  logic [3:0]        frame_decim,
  daq_capture_ctrl_if.slave bus,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              line_err,
  output logic              frame_err,
  output logic              ovf
);
  localparam int PW = $clog2(LINE_MAX + 1);
  localparam int LW = $clog2(FRAME_LINES + 2);
  localparam logic [PW-1:0] PIX_LAST = PW'(LINE_MAX - 1);
  localparam logic [PW-1:0] PIX_LINE = PW'(LINE_MAX);
  localparam logic [LW-1:0] LINES    = LW'(FRAME_LINES);
  typedef enum logic [1:0] {IDLE, ARM, CAPT, SKIP} state_t;
  state_t            state_q, state_d;
  logic              fv_q, lv_q;
  logic              single_q, single_d;
  logic [3:0]        decim_q, decim_d, skip_q, skip_d;
  logic [PW-1:0]     pix_cnt_q, pix_cnt_d, idx;
  logic [LW-1:0]     line_cnt_q, line_cnt_d, line_inc;
  logic              sof_q, sof_d, stop_pend_q, stop_pend_d;
  logic              wr_en_q, wr_en_d;
  logic [9:0]        wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              line_err_q, line_err_d, frame_err_q, frame_err_d, ovf_q, ovf_d;
  logic              fv_rise, fv_fall, lv_rise, lv_fall, acc;
  assign fv_rise  = bus.frame_vaild & ~fv_q;
  assign fv_fall  = ~bus.frame_vaild & fv_q;
  assign lv_rise  = bus.line_vaild & ~lv_q;
  assign lv_fall  = ~bus.line_vaild & lv_q;
  assign acc      = (state_q == CAPT) & bus.pix_stb & bus.frame_vaild & bus.line_vaild;
  // a pixel arriving with the line's rising edge is index 0, not the stale count
  assign idx      = lv_rise ? '0 : pix_cnt_q;
  assign line_inc = (&line_cnt_q) ? line_cnt_q : line_cnt_q + LW'(1);
  always_comb begin
    state_d      = state_q;
    single_d     = single_q;
    decim_d      = decim_q;
    skip_d       = skip_q;
    pix_cnt_d    = idx;
    line_cnt_d   = line_cnt_q;
    sof_d        = sof_q;
    stop_pend_d  = stop_pend_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    line_err_d   = line_err_q;
    frame_err_d  = frame_err_q;
    ovf_d        = ovf_q;
    case (state_q)
      IDLE: if (start && !stop) begin
        single_d    = single;
        decim_d     = frame_decim;
        skip_d      = '0;
        frame_cnt_d = '0;
        line_err_d  = 1'b0;
        frame_err_d = 1'b0;
        ovf_d       = 1'b0;
        state_d     = ARM;
      end
      ARM: if (stop) state_d = IDLE;
      else if (fv_rise) begin
        state_d    = (skip_q == '0) ? CAPT : SKIP;
        skip_d     = (skip_q == '0) ? decim_q : skip_q - 4'd1;
        line_cnt_d = '0;
        sof_d      = 1'b1;
      end
      SKIP: state_d = stop ? IDLE : (fv_fall ? ARM : SKIP);
      CAPT: begin
        if (stop) stop_pend_d = 1'b1;
        if (acc) begin
          pix_cnt_d = (&idx) ? idx : idx + PW'(1);
          sof_d     = 1'b0;
          ovf_d     = ovf_q | bus.fifo_full;
          wr_en_d   = ~bus.fifo_full;
          wr_data_d = bus.fifo_full ? wr_data_q : {sof_q, idx == PIX_LAST, bus.pix_data};
        end
        if (lv_fall) begin
          line_cnt_d = line_inc;
          if (pix_cnt_q != PIX_LINE) line_err_d = 1'b1;
        end
        if (fv_fall) begin
          if (line_cnt_d != LINES) frame_err_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + FCNT_W'(1);
          frame_done_d = 1'b1;
          line_cnt_d   = '0;
          stop_pend_d  = 1'b0;
          state_d      = (single_q || stop_pend_q || stop) ? IDLE : ARM;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      fv_q         <= 1'b0;
      lv_q         <= 1'b0;
      single_q     <= 1'b0;
      decim_q      <= '0;
      skip_q       <= '0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      sof_q        <= 1'b0;
      stop_pend_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fv_q         <= bus.frame_vaild;
      lv_q         <= bus.line_vaild;
      single_q     <= single_d;
      decim_q      <= decim_d;
      skip_q       <= skip_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      sof_q        <= sof_d;
      stop_pend_q  <= stop_pend_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
      ovf_q        <= ovf_d;
    end
  end
  assign busy        = state_q != IDLE;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_data = wr_data_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign line_err    = line_err_q;
  assign frame_err   = frame_err_q;
  assign ovf         = ovf_q;
endmodule

// File: tb/tb_daq_capture_ctrl.sv
// tb_daq_capture_ctrl: synthetic sensor source driving the capture controller,
// with a queue of expected FIFO words checked against every write.
module tb_daq_capture_ctrl;
  localparam int LINE_MAX = 100;
  localparam int FRAME_LINES = 20;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, single = 1'b0;
  logic [3:0]  decim = '0;
  logic        busy, frame_done, line_err, frame_err, ovf;
  logic [15:0] frame_cnt;
  logic [9:0]  exp_q[$];
  int          total = 0, bad = 0, wr_cnt = 0, fd_cnt = 0;
  daq_capture_ctrl_if bif();
  daq_capture_ctrl #(.LINE_MAX(LINE_MAX), .FRAME_LINES(FRAME_LINES), .FCNT_W(16)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .stop(stop), .single(single),
    .frame_decim(decim), .bus(bif), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .line_err(line_err), .frame_err(frame_err), .ovf(ovf));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, bif.wr_en, 0);
    check({tag, "_wr_data"}, bif.wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_fcnt"}, frame_cnt, 0);
    check({tag, "_errs"}, {line_err, frame_err, ovf}, 0);
  endtask
  always @(posedge clk) begin
    #1;
    if (bif.wr_en) begin
      wr_cnt++;
      check("wr_pend", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("wr_data", bif.wr_data, exp_q.pop_front());
    end
    if (frame_done) fd_cnt++;
  end
  task automatic cmd(input bit go, input bit halt, input bit s, input logic [3:0] d);
    @(negedge clk);
    start = go; stop = halt; single = s; decim = d;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask
  task automatic send_frame(input int nlines, input int short_line, input bit cap, input int full_lo,
                            input int full_hi, input int stop_at, input int rst_at, input bit tight);
    int g = 0;
    @(negedge clk);
    bif.frame_vaild = 1'b1;
    repeat (2) @(negedge clk);
    for (int l = 0; l < nlines; l++) begin
      int len = (l == short_line) ? LINE_MAX - 1 : LINE_MAX;
      for (int p = 0; p < len; p++) begin
        bif.line_vaild = 1'b1;
        bif.pix_stb = 1'b1;
        bif.pix_data = 8'($urandom);
        bif.fifo_full = (g >= full_lo) && (g < full_hi);
        stop = (g == stop_at);
        if (cap && !bif.fifo_full) exp_q.push_back({g == 0, p == LINE_MAX - 1, bif.pix_data});
        if (g == rst_at) begin
          #3 rst_n = 1'b0;
          #1 check_zero("rst_mid");
          exp_q.delete();
          cap = 1'b0;
        end
        g++;
        @(negedge clk);
        rst_n = 1'b1;
      end
      bif.pix_stb = 1'b0; bif.fifo_full = 1'b0; stop = 1'b0; bif.line_vaild = 1'b0;
      if (tight && l == nlines - 1) bif.frame_vaild = 1'b0;
      repeat (2) @(negedge clk);
    end
    bif.frame_vaild = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    bif.pix_stb = 1'b0; bif.frame_vaild = 1'b0; bif.line_vaild = 1'b0;
    bif.pix_data = '0; bif.fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    cmd(1, 1, 0, 0);
    check("start_stop_busy", busy, 0);
    // continuous capture, second frame drops line and frame valid together
    wr_cnt = 0; fd_cnt = 0;
    cmd(1, 0, 0, 0);
    send_frame(FRAME_LINES, -1, 1, -1, -1, -1, -1, 0);
    send_frame(FRAME_LINES, -1, 1, -1, -1, -1, -1, 1);
    check("t1_writes", wr_cnt, 4000);
    check("t1_done", fd_cnt, 2);
    check("t1_fcnt", frame_cnt, 2);
    check("t1_errs", {line_err, frame_err, ovf}, 0);
    check("t1_busy", busy, 1);
    cmd(0, 1, 0, 0);
    check("t1_stop_busy", busy, 0);
    // start mid-frame: that frame is ignored, next one captured with sof
    wr_cnt = 0;
    @(negedge clk);
    bif.frame_vaild = 1'b1; bif.line_vaild = 1'b1; bif.pix_stb = 1'b1;
    for (int i = 0; i < 120; i++) begin
      bif.pix_data = 8'($urandom);
      start = (i == 60); single = 1'b1; decim = '0;
      @(negedge clk);
    end
    start = 1'b0; bif.pix_stb = 1'b0; bif.line_vaild = 1'b0; bif.frame_vaild = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_nowrite", wr_cnt, 0);
    send_frame(FRAME_LINES, -1, 1, -1, -1, -1, -1, 0);
    check("t2_writes", wr_cnt, 2000);
    check("t2_single_idle", busy, 0);
    check("t2_fcnt", frame_cnt, 1);
    // decimation by 3 over 9 source frames
    wr_cnt = 0; fd_cnt = 0;
    cmd(1, 0, 0, 4'd2);
    for (int f = 0; f < 9; f++) send_frame(FRAME_LINES, -1, (f % 3) == 0, -1, -1, -1, -1, 0);
    check("t3_writes", wr_cnt, 6000);
    check("t3_done", fd_cnt, 3);
    check("t3_fcnt", frame_cnt, 3);
    cmd(0, 1, 0, 0);
    // fifo full for 10 accepted pixels
    wr_cnt = 0;
    cmd(1, 0, 1, 0);
    send_frame(FRAME_LINES, -1, 1, 300, 310, -1, -1, 0);
    check("t4_writes", wr_cnt, 1990);
    check("t4_ovf", ovf, 1);
    check("t4_err", {line_err, frame_err}, 0);
    check("t4_busy", busy, 0);
    cmd(1, 0, 0, 0);
    check("t4_ovf_clr", ovf, 0);
    cmd(0, 1, 0, 0);
    // short line, then short frame
    wr_cnt = 0;
    cmd(1, 0, 0, 0);
    send_frame(FRAME_LINES, 5, 1, -1, -1, -1, -1, 0);
    check("t5_line_err", line_err, 1);
    check("t5_frame_ok", frame_err, 0);
    send_frame(FRAME_LINES - 1, -1, 1, -1, -1, -1, -1, 0);
    check("t5_frame_err", frame_err, 1);
    check("t5_writes", wr_cnt, 1999 + 1900);
    check("t5_fcnt", frame_cnt, 2);
    cmd(0, 1, 0, 0);
    // stop mid-frame completes the frame
    wr_cnt = 0; fd_cnt = 0;
    cmd(1, 0, 0, 0);
    send_frame(FRAME_LINES, -1, 1, -1, -1, 500, -1, 0);
    check("t6_writes", wr_cnt, 2000);
    check("t6_done", fd_cnt, 1);
    check("t6_busy", busy, 0);
    // reset mid-frame, then no writes afterwards
    wr_cnt = 0;
    cmd(1, 0, 0, 0);
    send_frame(FRAME_LINES, -1, 1, -1, -1, -1, 700, 0);
    send_frame(FRAME_LINES, -1, 0, -1, -1, -1, -1, 0);
    check("t6_rst_writes", wr_cnt, 700);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_fcnt", frame_cnt, 0);
    check("t6_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
